axicb_mst_if_ostd: RTL and testbench
====================================

Name: axicb_mst_if_ostd

Overview:
- Next-generation crossbar master-side interface: sits between the crossbar switch output and one target slave port.
- Adds outstanding-transaction limiting per direction and AW-before-W ordering with locally regenerated WLAST.
- Adds response-timeout watchdogs, base-address removal, and sticky protocol/timeout error status.
- Supports AXI4 and AXI4-lite, single clock, no CDC.

Parameters:
- AXI_ADDR_W, 32, address width
- AXI_ID_W, 4, ID width
- AXI_DATA_W, 32, data width (multiple of 8)
- AXI_SIGNALING, 1, 0 = AXI4-lite (len forced 0, RLAST forced 1), 1 = AXI4
- KEEP_BASE_ADDR, 0, 0 = subtract BASE_ADDR from AW/AR address field
- BASE_ADDR, 0, target base address
- MAX_OSTD_WR, 4, max outstanding write transactions (1..255)
- MAX_OSTD_RD, 4, max outstanding read transactions (1..255)
- WLEN_DEPTH_LOG2, 2, log2 depth of the AW-length FIFO
- TIMEOUT_CYCLES, 1024, watchdog limit; 0 disables the watchdogs
- AWCH_W/ARCH_W, derived, packed AW/AR width = ADDR+ID+29 (AXI4) or ADDR+ID+3 (lite)
- WCH_W, derived, DATA + DATA/8
- BCH_W, derived, ID+2
- RCH_W, derived, DATA+2+ID

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- srst  in  1  synchronous reset, active high
- err_clr  in  1  pulse; clears err_status
- i_awvalid/i_awready  in/out  1  upstream AW handshake
- i_awch  in  AWCH_W  packed AW, address in LSBs, then id, len…
- i_wvalid/i_wready  in/out  1  upstream W handshake
- i_wlast  in  1  upstream WLAST (checked only)
- i_wch  in  WCH_W  packed W
- i_bvalid/i_bready  out/in  1  upstream B handshake
- i_bch  out  BCH_W  packed B
- i_arvalid/i_arready  in/out  1  upstream AR handshake
- i_arch  in  ARCH_W  packed AR
- i_rvalid/i_rready/i_rlast  out/in/out  1  upstream R
- i_rch  out  RCH_W  packed R
- o_aw*, o_w*, o_b*, o_ar*, o_r*: mirror of i_* toward the slave, same widths; o_wlast is an output
- err_status  out  5  sticky {rd_tmo, wr_tmo, unexp_r, unexp_b, wlast_mismatch}
- wr_ostd, rd_ostd  out  8 each  current outstanding counts

Behaviour:
- Reset (aresetn low, or srst high at a clock edge):
  - wr_ostd and rd_ostd = 0; err_status = 0; watchdogs = 0; beat counter = 0; WLEN FIFO empty.
  - All *valid/*ready outputs evaluate to 0 while reset is active.
  - srst mid-burst discards tracking immediately; it does not wait for drain.
- AW path (combinational, zero latency):
  - aw_ok = (wr_ostd < MAX_OSTD_WR) & !wlen_full.
  - o_awvalid = i_awvalid & aw_ok; i_awready = o_awready & aw_ok.
  - On the handshake, push awlen into the WLEN FIFO (lite: push 0).
- W path:
  - Forwarded only when the WLEN FIFO is non-empty: o_wvalid = i_wvalid & !wlen_empty; i_wready = o_wready & !wlen_empty.
  - An 8-bit beat counter gives o_wlast = (beat_cnt == fifo_head_len).
  - On the last-beat handshake: pop the FIFO and clear the counter. Otherwise the counter increments.
  - i_wlast != o_wlast at any handshake sets bit0. The data is still forwarded.
  - Same-cycle AW push into an empty FIFO does not enable W that cycle (registered FIFO, no fall-through).
- B path:
  - Pass-through.
  - Handshake with wr_ostd==0 sets bit1; the counter saturates at 0.
- AR path:
  - Same as AW: ar_ok = rd_ostd < MAX_OSTD_RD.
  - No FIFO is needed.
- R path:
  - Pass-through; i_rlast = o_rlast (lite: 1).
  - A handshake with rlast decrements rd_ostd.
  - rd_ostd==0 at that point sets bit2.
- Counter update:
  - wr_ostd_next = wr_ostd + aw_hs − (b_hs & wr_ostd>0).
  - Same for rd_ostd.
  - Simultaneous increment and decrement leaves the counter unchanged.
- Address: when KEEP_BASE_ADDR==0, o_awch address field = i_awch address − BASE_ADDR, mod 2^AXI_ADDR_W. Same for AR. Other fields are unchanged.
- Watchdogs (write and read, each a counter of width $clog2(TIMEOUT_CYCLES+1)):
  - Cleared when ostd==0 or on a B / R handshake.
  - Otherwise increment.
  - On reaching TIMEOUT_CYCLES: hold the value and set bit3 (wr) / bit4 (rd).
  - They do not affect traffic.
- err_status bits are sticky. err_clr clears them; a set in the same cycle wins over err_clr.

Decomposition:
- Package axicb_pkg holds:
  - packed-field offset functions (addr, id, len, prot) per AXI_SIGNALING;
  - channel-width functions;
  - err_status bit index constants.
- Sub-module: reuse axicb_scfifo (PASS_THRU=0, DATA_WIDTH=8, ADDR_WIDTH=WLEN_DEPTH_LOG2) for the WLEN FIFO.

Test Plan:
- MAX_OSTD_WR=2, 3 back-to-back AWs, slave withholds B → AW#3 stalls (i_awready=0, wr_ostd=2); one B → AW#3 accepted the next cycle.
- AW len=3 then 4 W beats, upstream WLAST on beat 4 → o_wlast only on beat 4, FIFO empty afterwards, err_status=0.
- W presented 5 cycles before AW → o_wvalid=0 until the cycle after the AW handshake; upstream WLAST on beat 2 of a len=3 burst → bit0 set.
- BASE_ADDR=0x1000_0000, AR address 0x1000_0040 → o_araddr 0x0000_0040; KEEP_BASE_ADDR=1 → 0x1000_0040 unchanged.
- TIMEOUT_CYCLES=16, one read with no R for 20 cycles → bit4 set at cycle 16; err_clr → 0; spurious B with wr_ostd=0 → bit1 set, wr_ostd stays 0.
- srst asserted mid-burst (beat 2 of len=7) → counters and FIFO cleared next edge, o_wvalid=0; a new burst then passes correctly.

Source files
------------

// File: rtl/axicb_pkg.sv
// Shared definitions for the crossbar master-side interface: packed channel
// layouts, channel widths and the bit positions inside err_status.
package axicb_pkg;

  // Bit positions inside the sticky err_status vector
  localparam int ERR_WLAST   = 0;
  localparam int ERR_UNEXP_B = 1;
  localparam int ERR_UNEXP_R = 2;
  localparam int ERR_WR_TMO  = 3;
  localparam int ERR_RD_TMO  = 4;
  localparam int ERR_W       = 5;

  // Packed AW/AR layout, LSB first:
  //   addr, id, len(8), size(3), burst(2), lock(1), cache(4), prot(3), qos(4), region(4)
  // In AXI4-lite only addr, id and prot are carried.
  function automatic int addr_off();
    return 0;
  endfunction

  function automatic int id_off(input int addr_w);
    return addr_w;
  endfunction

  function automatic int len_off(input int addr_w, input int id_w);
    return addr_w + id_w;
  endfunction

  function automatic int prot_off(input int addr_w, input int id_w, input int signaling);
    return (signaling != 0) ? (addr_w + id_w + 18) : (addr_w + id_w);
  endfunction

  function automatic int axch_w(input int addr_w, input int id_w, input int signaling);
    return addr_w + id_w + ((signaling != 0) ? 29 : 3);
  endfunction

  function automatic int wch_w(input int data_w);
    return data_w + data_w / 8;
  endfunction

  function automatic int bch_w(input int id_w);
    return id_w + 2;
  endfunction

  function automatic int rch_w(input int data_w, input int id_w);
    return data_w + 2 + id_w;
  endfunction

endpackage

// File: rtl/axicb_scfifo.sv
// Single-clock FIFO with optional fall-through. Used to hold AW burst lengths
// until the matching write data has been forwarded.
module axicb_scfifo #(
  parameter int PASS_THRU  = 0,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_full,
  input  logic                  i_pull,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_empty
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = DEPTH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  w_stored_empty;
  logic                  w_bypass;
  logic                  w_wr_en;
  logic                  w_rd_en;

  assign w_stored_empty = (r_count == '0);
  assign w_bypass       = (PASS_THRU != 0) && w_stored_empty && i_push && i_pull;
  assign o_full         = (r_count == DEPTH_L);
  assign o_empty        = (PASS_THRU != 0) ? (w_stored_empty & ~i_push) : w_stored_empty;
  assign o_data         = ((PASS_THRU != 0) && w_stored_empty) ? i_data : r_mem[r_rd_ptr];
  assign w_wr_en        = i_push & ~o_full & ~w_bypass;
  assign w_rd_en        = i_pull & ~w_stored_empty;

  // Storage array, written on every accepted push
  always_ff @(posedge aclk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers and occupancy; srst empties the FIFO immediately
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/axicb_mst_if_ostd.sv
// Crossbar master-side interface toward one slave: limits outstanding
// transactions, orders W behind AW with locally generated WLAST, strips the
// target base address and keeps sticky protocol/timeout status.
module axicb_mst_if_ostd
  import axicb_pkg::*;
#(
  parameter int                  AXI_ADDR_W      = 32,
  parameter int                  AXI_ID_W        = 4,
  parameter int                  AXI_DATA_W      = 32,
  parameter int                  AXI_SIGNALING   = 1,
  parameter int                  KEEP_BASE_ADDR  = 0,
  parameter logic [AXI_ADDR_W-1:0] BASE_ADDR     = '0,
  parameter int                  MAX_OSTD_WR     = 4,
  parameter int                  MAX_OSTD_RD     = 4,
  parameter int                  WLEN_DEPTH_LOG2 = 2,
  parameter int                  TIMEOUT_CYCLES  = 1024,
  localparam int                 AWCH_W = axch_w(AXI_ADDR_W, AXI_ID_W, AXI_SIGNALING),
  localparam int                 ARCH_W = axch_w(AXI_ADDR_W, AXI_ID_W, AXI_SIGNALING),
  localparam int                 WCH_W  = wch_w(AXI_DATA_W),
  localparam int                 BCH_W  = bch_w(AXI_ID_W),
  localparam int                 RCH_W  = rch_w(AXI_DATA_W, AXI_ID_W)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              srst,
  input  logic              err_clr,
  // upstream (crossbar switch side)
  input  logic              i_awvalid,
  output logic              i_awready,
  input  logic [AWCH_W-1:0] i_awch,
  input  logic              i_wvalid,
  output logic              i_wready,
  input  logic              i_wlast,
  input  logic [WCH_W-1:0]  i_wch,
  output logic              i_bvalid,
  input  logic              i_bready,
  output logic [BCH_W-1:0]  i_bch,
  input  logic              i_arvalid,
  output logic              i_arready,
  input  logic [ARCH_W-1:0] i_arch,
  output logic              i_rvalid,
  input  logic              i_rready,
  output logic              i_rlast,
  output logic [RCH_W-1:0]  i_rch,
  // downstream (slave side)
  output logic              o_awvalid,
  input  logic              o_awready,
  output logic [AWCH_W-1:0] o_awch,
  output logic              o_wvalid,
  input  logic              o_wready,
  output logic              o_wlast,
  output logic [WCH_W-1:0]  o_wch,
  input  logic              o_bvalid,
  output logic              o_bready,
  input  logic [BCH_W-1:0]  o_bch,
  output logic              o_arvalid,
  input  logic              o_arready,
  output logic [ARCH_W-1:0] o_arch,
  input  logic              o_rvalid,
  output logic              o_rready,
  input  logic              o_rlast,
  input  logic [RCH_W-1:0]  o_rch,
  // status
  output logic [ERR_W-1:0]  err_status,
  output logic [7:0]        wr_ostd,
  output logic [7:0]        rd_ostd
);

  localparam int               LEN_OFF  = len_off(AXI_ADDR_W, AXI_ID_W);
  localparam logic [7:0]       MAX_WR_L = MAX_OSTD_WR[7:0];
  localparam logic [7:0]       MAX_RD_L = MAX_OSTD_RD[7:0];
  localparam bit               TMO_EN   = (TIMEOUT_CYCLES > 0);
  localparam int               TMO_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

  logic             w_run;
  logic             w_aw_ok;
  logic             w_ar_ok;
  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_b_hs;
  logic             w_ar_hs;
  logic             w_r_hs;
  logic             w_wr_dec;
  logic             w_rd_dec;
  logic [7:0]       w_awlen;
  logic [7:0]       w_wlen_head;
  logic             w_wlen_full;
  logic             w_wlen_empty;
  logic             w_wlen_pull;
  logic [AXI_ADDR_W-1:0] w_aw_addr;
  logic [AXI_ADDR_W-1:0] w_ar_addr;
  logic [ERR_W-1:0] w_err_set;
  logic [TMO_W-1:0] w_wr_wdog_nxt;
  logic [TMO_W-1:0] w_rd_wdog_nxt;
  logic             w_wr_tmo_set;
  logic             w_rd_tmo_set;

  logic [7:0]       r_wr_ostd;
  logic [7:0]       r_rd_ostd;
  logic [7:0]       r_beat_cnt;
  logic [ERR_W-1:0] r_err;
  logic [TMO_W-1:0] r_wr_wdog;
  logic [TMO_W-1:0] r_rd_wdog;

  // All handshake outputs are forced low while either reset is active
  assign w_run = aresetn & ~srst;

  assign w_aw_ok   = (r_wr_ostd < MAX_WR_L) & ~w_wlen_full;
  assign w_ar_ok   = (r_rd_ostd < MAX_RD_L);

  assign o_awvalid = i_awvalid & w_aw_ok & w_run;
  assign i_awready = o_awready & w_aw_ok & w_run;
  assign o_arvalid = i_arvalid & w_ar_ok & w_run;
  assign i_arready = o_arready & w_ar_ok & w_run;

  assign o_wvalid  = i_wvalid & ~w_wlen_empty & w_run;
  assign i_wready  = o_wready & ~w_wlen_empty & w_run;
  assign o_wch     = i_wch;
  assign o_wlast   = (r_beat_cnt == w_wlen_head);

  assign i_bvalid  = o_bvalid & w_run;
  assign o_bready  = i_bready & w_run;
  assign i_bch     = o_bch;

  assign i_rvalid  = o_rvalid & w_run;
  assign o_rready  = i_rready & w_run;
  assign i_rch     = o_rch;

  assign w_aw_hs   = o_awvalid & o_awready;
  assign w_w_hs    = o_wvalid & o_wready;
  assign w_b_hs    = i_bvalid & i_bready;
  assign w_ar_hs   = o_arvalid & o_arready;
  assign w_r_hs    = i_rvalid & i_rready;

  assign w_wr_dec  = w_b_hs & (r_wr_ostd != 8'd0);
  assign w_rd_dec  = w_r_hs & i_rlast & (r_rd_ostd != 8'd0);

  if (AXI_SIGNALING != 0) begin : g_axi4
    assign w_awlen = i_awch[LEN_OFF +: 8];
    assign i_rlast = o_rlast;
  end else begin : g_lite
    assign w_awlen = 8'd0;
    assign i_rlast = 1'b1;
  end

  // Address rebasing: the slave sees offsets relative to its own window
  assign w_aw_addr = (KEEP_BASE_ADDR != 0) ? i_awch[AXI_ADDR_W-1:0]
                                           : i_awch[AXI_ADDR_W-1:0] - BASE_ADDR;
  assign w_ar_addr = (KEEP_BASE_ADDR != 0) ? i_arch[AXI_ADDR_W-1:0]
                                           : i_arch[AXI_ADDR_W-1:0] - BASE_ADDR;
  assign o_awch    = {i_awch[AWCH_W-1:AXI_ADDR_W], w_aw_addr};
  assign o_arch    = {i_arch[ARCH_W-1:AXI_ADDR_W], w_ar_addr};

  assign w_wlen_pull = w_w_hs & o_wlast;

  axicb_scfifo #(
    .PASS_THRU  (0),
    .DATA_WIDTH (8),
    .ADDR_WIDTH (WLEN_DEPTH_LOG2)
  ) u_wlen_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .srst    (srst),
    .i_push  (w_aw_hs),
    .i_data  (w_awlen),
    .o_full  (w_wlen_full),
    .i_pull  (w_wlen_pull),
    .o_data  (w_wlen_head),
    .o_empty (w_wlen_empty)
  );

  // Watchdogs run while transactions are pending and flag only the crossing
  // into timeout, so err_clr can clear the bit while the counter stays parked
  always_comb begin
    w_wr_wdog_nxt = r_wr_wdog;
    w_wr_tmo_set  = 1'b0;
    w_rd_wdog_nxt = r_rd_wdog;
    w_rd_tmo_set  = 1'b0;
    if (!TMO_EN || r_wr_ostd == 8'd0 || w_b_hs) begin
      w_wr_wdog_nxt = '0;
    end else if (r_wr_wdog != TMO_MAX) begin
      w_wr_wdog_nxt = r_wr_wdog + 1'b1;
      w_wr_tmo_set  = (r_wr_wdog == TMO_MAX - 1'b1);
    end
    if (!TMO_EN || r_rd_ostd == 8'd0 || w_r_hs) begin
      w_rd_wdog_nxt = '0;
    end else if (r_rd_wdog != TMO_MAX) begin
      w_rd_wdog_nxt = r_rd_wdog + 1'b1;
      w_rd_tmo_set  = (r_rd_wdog == TMO_MAX - 1'b1);
    end
  end

  // Error events detected this cycle
  always_comb begin
    w_err_set              = '0;
    w_err_set[ERR_WLAST]   = w_w_hs & (i_wlast != o_wlast);
    w_err_set[ERR_UNEXP_B] = w_b_hs & (r_wr_ostd == 8'd0);
    w_err_set[ERR_UNEXP_R] = w_r_hs & i_rlast & (r_rd_ostd == 8'd0);
    w_err_set[ERR_WR_TMO]  = w_wr_tmo_set;
    w_err_set[ERR_RD_TMO]  = w_rd_tmo_set;
  end

  // Tracking state; srst drops all pending bookkeeping without draining
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ostd  <= '0;
      r_rd_ostd  <= '0;
      r_beat_cnt <= '0;
      r_err      <= '0;
      r_wr_wdog  <= '0;
      r_rd_wdog  <= '0;
    end else if (srst) begin
      r_wr_ostd  <= '0;
      r_rd_ostd  <= '0;
      r_beat_cnt <= '0;
      r_err      <= '0;
      r_wr_wdog  <= '0;
      r_rd_wdog  <= '0;
    end else begin
      r_wr_ostd <= r_wr_ostd + {7'd0, w_aw_hs} - {7'd0, w_wr_dec};
      r_rd_ostd <= r_rd_ostd + {7'd0, w_ar_hs} - {7'd0, w_rd_dec};
      if (w_w_hs) r_beat_cnt <= o_wlast ? 8'd0 : r_beat_cnt + 8'd1;
      r_err     <= (err_clr ? '0 : r_err) | w_err_set;
      r_wr_wdog <= w_wr_wdog_nxt;
      r_rd_wdog <= w_rd_wdog_nxt;
    end
  end

  assign err_status = r_err;
  assign wr_ostd    = r_wr_ostd;
  assign rd_ostd    = r_rd_ostd;

endmodule

// File: tb/tb_axicb_mst_if_ostd.sv
// Directed bench for axicb_mst_if_ostd: outstanding limit, WLAST regeneration,
// W-behind-AW ordering, base-address stripping, watchdogs, spurious responses
// and synchronous reset in the middle of a burst.
module tb_axicb_mst_if_ostd;

  localparam int AWCH_W = 65;
  localparam int WCH_W  = 36;
  localparam int BCH_W  = 6;
  localparam int RCH_W  = 38;

  logic              aclk;
  logic              aresetn;
  logic              srst;
  logic              err_clr;
  logic              i_awvalid, i_awready;
  logic [AWCH_W-1:0] i_awch;
  logic              i_wvalid, i_wready, i_wlast;
  logic [WCH_W-1:0]  i_wch;
  logic              i_bvalid, i_bready;
  logic [BCH_W-1:0]  i_bch;
  logic              i_arvalid, i_arready;
  logic [AWCH_W-1:0] i_arch;
  logic              i_rvalid, i_rready, i_rlast;
  logic [RCH_W-1:0]  i_rch;
  logic              o_awvalid, o_awready;
  logic [AWCH_W-1:0] o_awch;
  logic              o_wvalid, o_wready, o_wlast;
  logic [WCH_W-1:0]  o_wch;
  logic              o_bvalid, o_bready;
  logic [BCH_W-1:0]  o_bch;
  logic              o_arvalid, o_arready;
  logic [AWCH_W-1:0] o_arch;
  logic              o_rvalid, o_rready, o_rlast;
  logic [RCH_W-1:0]  o_rch;
  logic [4:0]        err_status;
  logic [7:0]        wr_ostd, rd_ostd;

  logic              k_awready, k_wready, k_bvalid, k_arready, k_rvalid, k_rlast;
  logic [BCH_W-1:0]  k_bch;
  logic [RCH_W-1:0]  k_rch;
  logic              k_awvalid, k_wvalid, k_wlast, k_bready, k_arvalid, k_rready;
  logic [AWCH_W-1:0] k_awch, k_arch;
  logic [WCH_W-1:0]  k_wch;
  logic [4:0]        k_err;
  logic [7:0]        k_wr_ostd, k_rd_ostd;

  int nTests;
  int nFail;

  axicb_mst_if_ostd #(
    .MAX_OSTD_WR    (2),
    .MAX_OSTD_RD    (4),
    .KEEP_BASE_ADDR (0),
    .BASE_ADDR      (32'h1000_0000),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst), .err_clr(err_clr),
    .i_awvalid(i_awvalid), .i_awready(i_awready), .i_awch(i_awch),
    .i_wvalid(i_wvalid), .i_wready(i_wready), .i_wlast(i_wlast), .i_wch(i_wch),
    .i_bvalid(i_bvalid), .i_bready(i_bready), .i_bch(i_bch),
    .i_arvalid(i_arvalid), .i_arready(i_arready), .i_arch(i_arch),
    .i_rvalid(i_rvalid), .i_rready(i_rready), .i_rlast(i_rlast), .i_rch(i_rch),
    .o_awvalid(o_awvalid), .o_awready(o_awready), .o_awch(o_awch),
    .o_wvalid(o_wvalid), .o_wready(o_wready), .o_wlast(o_wlast), .o_wch(o_wch),
    .o_bvalid(o_bvalid), .o_bready(o_bready), .o_bch(o_bch),
    .o_arvalid(o_arvalid), .o_arready(o_arready), .o_arch(o_arch),
    .o_rvalid(o_rvalid), .o_rready(o_rready), .o_rlast(o_rlast), .o_rch(o_rch),
    .err_status(err_status), .wr_ostd(wr_ostd), .rd_ostd(rd_ostd)
  );

  axicb_mst_if_ostd #(
    .KEEP_BASE_ADDR (1),
    .BASE_ADDR      (32'h1000_0000)
  ) dut_keep (
    .aclk(aclk), .aresetn(aresetn), .srst(srst), .err_clr(err_clr),
    .i_awvalid(i_awvalid), .i_awready(k_awready), .i_awch(i_awch),
    .i_wvalid(i_wvalid), .i_wready(k_wready), .i_wlast(i_wlast), .i_wch(i_wch),
    .i_bvalid(k_bvalid), .i_bready(i_bready), .i_bch(k_bch),
    .i_arvalid(i_arvalid), .i_arready(k_arready), .i_arch(i_arch),
    .i_rvalid(k_rvalid), .i_rready(i_rready), .i_rlast(k_rlast), .i_rch(k_rch),
    .o_awvalid(k_awvalid), .o_awready(o_awready), .o_awch(k_awch),
    .o_wvalid(k_wvalid), .o_wready(o_wready), .o_wlast(k_wlast), .o_wch(k_wch),
    .o_bvalid(o_bvalid), .o_bready(k_bready), .o_bch(o_bch),
    .o_arvalid(k_arvalid), .o_arready(o_arready), .o_arch(k_arch),
    .o_rvalid(o_rvalid), .o_rready(k_rready), .o_rlast(o_rlast), .o_rch(o_rch),
    .err_status(k_err), .wr_ostd(k_wr_ostd), .rd_ostd(k_rd_ostd)
  );

  // 100 MHz-style free-running clock
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Hard stop in case the directed sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL time_limit: observed still running, expected finished");
    $fatal(1, "[TB] time limit reached");
  end

  function automatic logic [AWCH_W-1:0] mkAx(input logic [31:0] addr, input logic [3:0] id,
                                              input logic [7:0] len);
    logic [AWCH_W-1:0] v;
    v        = '0;
    v[31:0]  = addr;
    v[35:32] = id;
    v[43:36] = len;
    v[46:44] = 3'd2;
    v[48:47] = 2'd1;
    return v;
  endfunction

  task automatic nextCycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] addr,
                               input logic [3:0] id, input logic [7:0] len);
    i_awvalid = valid;
    i_awch    = mkAx(addr, id, len);
    o_awready = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nTests++;
    assert (observed === expected)
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    nTests = 0;
    nFail  = 0;

    // reset active with every request/response asserted upstream and downstream
    aresetn = 1'b0; srst = 1'b0; err_clr = 1'b0;
    i_awvalid = 1'b1; i_awch = mkAx(32'h1000_0100, 4'd1, 8'd0); o_awready = 1'b1;
    i_wvalid = 1'b1; i_wlast = 1'b1; i_wch = '0; o_wready = 1'b1;
    o_bvalid = 1'b1; o_bch = '0; i_bready = 1'b1;
    i_arvalid = 1'b1; i_arch = '0; o_arready = 1'b1;
    o_rvalid = 1'b1; o_rlast = 1'b1; o_rch = '0; i_rready = 1'b1;
    #2;
    checkOutput("rst_o_awvalid", o_awvalid, 0);
    checkOutput("rst_i_awready", i_awready, 0);
    checkOutput("rst_o_wvalid", o_wvalid, 0);
    checkOutput("rst_i_bvalid", i_bvalid, 0);
    checkOutput("rst_o_bready", o_bready, 0);
    checkOutput("rst_i_arready", i_arready, 0);
    checkOutput("rst_i_rvalid", i_rvalid, 0);
    checkOutput("rst_wr_ostd", wr_ostd, 0);
    checkOutput("rst_rd_ostd", rd_ostd, 0);
    checkOutput("rst_err", err_status, 0);
    i_awvalid = 1'b0; i_wvalid = 1'b0; i_wlast = 1'b0; o_bvalid = 1'b0;
    i_arvalid = 1'b0; o_rvalid = 1'b0; o_rlast = 1'b0;
    #20;
    aresetn = 1'b1;

    // outstanding write limit of 2 with B withheld
    nextCycle();
    applyStimulus(1'b1, 32'h1000_0100, 4'd1, 8'd0);
    #1;
    checkOutput("aw1_o_awvalid", o_awvalid, 1);
    checkOutput("aw1_i_awready", i_awready, 1);
    checkOutput("aw1_addr_strip", o_awch[31:0], 32'h0000_0100);
    checkOutput("aw1_len_pass", o_awch[43:36], 0);
    nextCycle();
    checkOutput("aw1_wr_ostd", wr_ostd, 1);
    nextCycle();
    checkOutput("aw2_wr_ostd", wr_ostd, 2);
    checkOutput("aw3_stall_ready", i_awready, 0);
    checkOutput("aw3_stall_valid", o_awvalid, 0);
    nextCycle();
    checkOutput("aw3_stall_hold", wr_ostd, 2);
    o_bvalid = 1'b1;
    #1;
    checkOutput("b1_i_bvalid", i_bvalid, 1);
    checkOutput("b1_aw_still_stalled", i_awready, 0);
    nextCycle();
    o_bvalid = 1'b0;
    #1;
    checkOutput("b1_wr_ostd", wr_ostd, 1);
    checkOutput("aw3_ready_after_b", i_awready, 1);
    nextCycle();
    i_awvalid = 1'b0;
    checkOutput("aw3_wr_ostd", wr_ostd, 2);
    o_bvalid = 1'b1;
    nextCycle();
    nextCycle();
    o_bvalid = 1'b0;
    checkOutput("b_drain_wr_ostd", wr_ostd, 0);

    // three single-beat writes drain the length FIFO
    i_wvalid = 1'b1; i_wlast = 1'b1; i_wch = 36'hF_A5A5_0001;
    #1;
    checkOutput("w_single_valid", o_wvalid, 1);
    checkOutput("w_single_last", o_wlast, 1);
    checkOutput("w_single_data", o_wch, 36'hF_A5A5_0001);
    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("w_fifo_empty_valid", o_wvalid, 0);
    checkOutput("w_fifo_empty_ready", i_wready, 0);
    i_wvalid = 1'b0; i_wlast = 1'b0;
    checkOutput("w_single_err", err_status, 0);

    // len=3 burst, upstream WLAST on the fourth beat
    applyStimulus(1'b1, 32'h1000_0200, 4'd2, 8'd3);
    nextCycle();
    i_awvalid = 1'b0;
    checkOutput("b4_wr_ostd", wr_ostd, 1);
    i_wvalid = 1'b1;
    for (int b = 0; b < 4; b++) begin
      i_wlast = (b == 3);
      i_wch   = 36'h0_0000_0100 + 36'(b);
      #1;
      checkOutput("b4_o_wvalid", o_wvalid, 1);
      checkOutput("b4_o_wlast", o_wlast, (b == 3) ? 64'd1 : 64'd0);
      nextCycle();
    end
    i_wvalid = 1'b0; i_wlast = 1'b0;
    #1;
    checkOutput("b4_fifo_empty", i_wready, 0);
    checkOutput("b4_err", err_status, 0);
    o_bvalid = 1'b1;
    nextCycle();
    o_bvalid = 1'b0;
    checkOutput("b4_b_wr_ostd", wr_ostd, 0);

    // W waiting ahead of AW, then early upstream WLAST
    i_wvalid = 1'b1; i_wlast = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checkOutput("early_w_blocked", o_wvalid, 0);
      nextCycle();
    end
    applyStimulus(1'b1, 32'h1000_0300, 4'd3, 8'd3);
    #1;
    checkOutput("early_aw_ready", i_awready, 1);
    checkOutput("early_no_fallthru", o_wvalid, 0);
    nextCycle();
    i_awvalid = 1'b0;
    #1;
    checkOutput("early_w_enabled", o_wvalid, 1);
    checkOutput("early_beat0_last", o_wlast, 0);
    nextCycle();
    i_wlast = 1'b1;
    #1;
    checkOutput("early_beat1_last", o_wlast, 0);
    nextCycle();
    i_wlast = 1'b0;
    checkOutput("wlast_mismatch_err", err_status, 5'b00001);
    nextCycle();
    i_wlast = 1'b1;
    #1;
    checkOutput("early_beat3_last", o_wlast, 1);
    nextCycle();
    i_wvalid = 1'b0; i_wlast = 1'b0;
    checkOutput("wlast_err_sticky", err_status, 5'b00001);
    err_clr = 1'b1;
    nextCycle();
    err_clr = 1'b0;
    checkOutput("err_clr_wlast", err_status, 0);
    o_bvalid = 1'b1;
    nextCycle();
    o_bvalid = 1'b0;
    checkOutput("early_b_wr_ostd", wr_ostd, 0);

    // base address stripping on AR and read watchdog
    i_arvalid = 1'b1; i_arch = mkAx(32'h1000_0040, 4'd5, 8'd0); o_arready = 1'b1;
    #1;
    checkOutput("ar_o_arvalid", o_arvalid, 1);
    checkOutput("ar_i_arready", i_arready, 1);
    checkOutput("ar_addr_strip", o_arch[31:0], 32'h0000_0040);
    checkOutput("ar_addr_keep", k_arch[31:0], 32'h1000_0040);
    checkOutput("ar_id_pass", o_arch[35:32], 5);
    nextCycle();
    i_arvalid = 1'b0;
    checkOutput("ar_rd_ostd", rd_ostd, 1);
    for (int c = 0; c < 15; c++) nextCycle();
    checkOutput("rd_tmo_before", err_status, 0);
    nextCycle();
    checkOutput("rd_tmo_at16", err_status, 5'b10000);
    for (int c = 0; c < 4; c++) nextCycle();
    checkOutput("rd_tmo_hold", err_status, 5'b10000);
    checkOutput("rd_tmo_ostd", rd_ostd, 1);
    err_clr = 1'b1;
    nextCycle();
    err_clr = 1'b0;
    checkOutput("rd_tmo_clr", err_status, 0);
    o_rvalid = 1'b1; o_rlast = 1'b1; o_rch = 38'h2A_1234_5678; i_rready = 1'b1;
    #1;
    checkOutput("r_i_rvalid", i_rvalid, 1);
    checkOutput("r_i_rlast", i_rlast, 1);
    checkOutput("r_i_rch", i_rch, 38'h2A_1234_5678);
    checkOutput("r_o_rready", o_rready, 1);
    nextCycle();
    o_rvalid = 1'b0; o_rlast = 1'b0;
    checkOutput("r_rd_ostd", rd_ostd, 0);
    checkOutput("r_err", err_status, 0);

    // spurious responses with nothing outstanding
    o_bvalid = 1'b1; i_bready = 1'b1;
    nextCycle();
    o_bvalid = 1'b0;
    checkOutput("unexp_b_err", err_status, 5'b00010);
    checkOutput("unexp_b_wr_ostd", wr_ostd, 0);
    o_rvalid = 1'b1; o_rlast = 1'b1;
    nextCycle();
    o_rvalid = 1'b0; o_rlast = 1'b0;
    checkOutput("unexp_r_err", err_status, 5'b00110);
    checkOutput("unexp_r_rd_ostd", rd_ostd, 0);
    err_clr = 1'b1;
    nextCycle();
    err_clr = 1'b0;
    checkOutput("unexp_clr", err_status, 0);

    // synchronous reset in the middle of a len=7 burst
    applyStimulus(1'b1, 32'h1000_0400, 4'd6, 8'd7);
    i_arvalid = 1'b1; i_arch = mkAx(32'h1000_0500, 4'd6, 8'd0);
    nextCycle();
    i_awvalid = 1'b0; i_arvalid = 1'b0;
    checkOutput("srst_pre_rd_ostd", rd_ostd, 1);
    i_wvalid = 1'b1; i_wlast = 1'b0;
    nextCycle();
    nextCycle();
    srst = 1'b1;
    #1;
    checkOutput("srst_o_wvalid_gated", o_wvalid, 0);
    checkOutput("srst_i_wready_gated", i_wready, 0);
    nextCycle();
    srst = 1'b0;
    #1;
    checkOutput("srst_wr_ostd", wr_ostd, 0);
    checkOutput("srst_rd_ostd", rd_ostd, 0);
    checkOutput("srst_fifo_empty", o_wvalid, 0);
    i_wvalid = 1'b0;
    applyStimulus(1'b1, 32'h1000_0600, 4'd7, 8'd1);
    #1;
    checkOutput("post_srst_aw_ready", i_awready, 1);
    nextCycle();
    i_awvalid = 1'b0;
    i_wvalid = 1'b1; i_wlast = 1'b0;
    #1;
    checkOutput("post_srst_beat0_last", o_wlast, 0);
    nextCycle();
    i_wlast = 1'b1;
    #1;
    checkOutput("post_srst_beat1_last", o_wlast, 1);
    nextCycle();
    i_wvalid = 1'b0; i_wlast = 1'b0;
    #1;
    checkOutput("post_srst_fifo_empty", i_wready, 0);
    checkOutput("post_srst_err", err_status, 0);
    checkOutput("post_srst_wr_ostd", wr_ostd, 1);
    o_bvalid = 1'b1;
    nextCycle();
    o_bvalid = 1'b0;
    checkOutput("post_srst_b_wr_ostd", wr_ostd, 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
